// File: rtl/scv_scandoubler.sv
// scv_scandoubler: buffers each CE-qualified input line and replays it twice at double pixel rate.
// Optional feature macro SCAN_SCANLINES_EN: halves every RGB channel on the repeated output line.
module scv_scandoubler #(
  parameter int MAXW   = 512,
  parameter int CE_DLY = 4
) (
  input  logic        CLK,
  input  logic        RESB,
  input  logic        CE,
  input  logic        DE,
  input  logic        HS,
  input  logic        VS,
  input  logic [23:0] RGB,
  output logic        CE_O,
  output logic        DE_O,
  output logic        HS_O,
  output logic        VS_O,
  output logic [23:0] RGB_O
);
  localparam int AW = $clog2(MAXW);
  localparam logic [AW:0] WFULL = (AW+1)'(MAXW);

  logic [2:0]         ce_cnt;
  logic               tick;
  logic               seen, hs_q, de_q, de_in;
  logic               hs_rise, hs_fall, de_rise, de_fall;
  logic [9:0]         hcnt, htot, hsw, dstart, x_cur;
  logic [AW:0]        wx;
  logic [1:0][AW:0]   len;
  logic               wbank, wbank_nxt, rbank;
  logic [9:0]         ox;
  logic               rep, vs_line, line_start;
  logic               de_c, hs_c, vs_c;
  logic [10:0]        de_end;
  logic [AW-1:0]      rx;
  logic [AW:0]        raddr;
  logic [23:0]        mem [2*MAXW];
  logic [23:0]        rdata, pix;
  logic               de_p, hs_p, vs_p;
`ifdef SCAN_SCANLINES_EN
  logic               rep_p;
`endif

  // Cycles since the last CE, saturating so the second strobe fires once per period.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB)                ce_cnt <= '0;
    else if (CE)              ce_cnt <= 3'd1;
    else if (ce_cnt != 3'd7)  ce_cnt <= ce_cnt + 3'd1;
  end

  assign tick = CE | (ce_cnt == 3'(CE_DLY));

  // Nothing is captured until the first HS rise, so a line cut by reset is never stored.
  assign de_in   = DE & seen;
  assign hs_rise = CE & HS & ~hs_q;
  assign hs_fall = CE & ~HS & hs_q;
  assign de_rise = CE & de_in & ~de_q;
  assign de_fall = CE & ~de_in & de_q;
  assign x_cur   = hs_rise ? 10'd0 : hcnt;

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      seen   <= 1'b0;
      hs_q   <= 1'b0;
      de_q   <= 1'b0;
      hcnt   <= '0;
      htot   <= '0;
      hsw    <= '0;
      dstart <= '0;
    end else if (CE) begin
      hs_q <= HS;
      de_q <= de_in;
      if (hs_rise) begin
        seen <= 1'b1;
        hcnt <= 10'd1;
        if (seen) htot <= hcnt;
      end else if (seen && hcnt != 10'h3FF) begin
        hcnt <= hcnt + 10'd1;
      end
      if (hs_fall) hsw    <= x_cur;
      if (de_rise) dstart <= x_cur;
    end
  end

  assign wbank_nxt = de_fall ? ~wbank : wbank;

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      wx    <= '0;
      len   <= '0;
      wbank <= 1'b0;
    end else if (CE) begin
      if (de_fall) begin
        len[wbank] <= wx;
        wbank      <= ~wbank;
        wx         <= '0;
      end else if (de_in && wx != WFULL) begin
        wx <= wx + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CE && de_in && wx != WFULL) mem[{wbank, wx[AW-1:0]}] <= RGB;
    rdata <= mem[raddr];
  end

  // Read bank swaps only when a fresh rep-0 output line begins.
  assign line_start = hs_rise | ((htot != 10'd0) && rep && (ox == htot - 10'd1));
  assign de_end     = {1'b0, dstart} + 11'(len[rbank]);
  assign hs_c       = (htot != 10'd0) && (ox < hsw);
  assign de_c       = (htot != 10'd0) && ({1'b0, ox} >= {1'b0, dstart}) && ({1'b0, ox} < de_end);
  assign vs_c       = (ox == 10'd0) ? VS : vs_line;
  assign rx         = AW'(ox - dstart);

`ifdef SCAN_SCANLINES_EN
  assign pix = rep_p ? {1'b0, rdata[23:17], 1'b0, rdata[15:9], 1'b0, rdata[7:1]} : rdata;
`else
  assign pix = rdata;
`endif

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      ox      <= '0;
      rep     <= 1'b0;
      rbank   <= 1'b1;
      vs_line <= 1'b0;
      raddr   <= '0;
      de_p    <= 1'b0;
      hs_p    <= 1'b0;
      vs_p    <= 1'b0;
`ifdef SCAN_SCANLINES_EN
      rep_p   <= 1'b0;
`endif
      CE_O    <= 1'b0;
      DE_O    <= 1'b0;
      HS_O    <= 1'b0;
      VS_O    <= 1'b0;
      RGB_O   <= '0;
    end else begin
      CE_O <= tick;
      if (tick) begin
        if (hs_rise) begin
          ox  <= '0;
          rep <= 1'b0;
        end else if (htot != 10'd0) begin
          if (ox == htot - 10'd1) begin
            ox  <= '0;
            rep <= ~rep;
          end else begin
            ox <= ox + 10'd1;
          end
        end
        if (line_start)   rbank   <= ~wbank_nxt;
        if (ox == 10'd0)  vs_line <= VS;
        // Address issue stage; the RAM word is ready well before the next strobe.
        raddr <= {rbank, rx};
        de_p  <= de_c;
        hs_p  <= hs_c;
        vs_p  <= vs_c;
`ifdef SCAN_SCANLINES_EN
        rep_p <= rep;
`endif
        DE_O  <= de_p;
        HS_O  <= hs_p;
        VS_O  <= vs_p;
        RGB_O <= de_p ? pix : 24'h0;
      end
    end
  end
endmodule
